mips_multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing a multicycle MIPS datapath: shared memory port, IR, register file, ALU and the
//  16->32 immediate extender. Drives every datapath select/enable, including sign- vs zero-extend of imm.

---
 rtl/mips_ctrl_pkg.sv | 91 +++++++++
 rtl/alu_decoder.sv | 50 +++++
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode/funct constants, ALU control codes, mux select encodings, the ALU
// operation class used to steer the ALU decoder, and the bundle of datapath
// control strobes driven by the FSM.
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // What kind of ALU operation the current state wants
    typedef enum logic [1:0] {
        ALU_CLS_ADD,    // address / PC arithmetic
        ALU_CLS_SUB,    // beq compare
        ALU_CLS_FUNCT,  // R-type, decoded from funct
        ALU_CLS_IMM     // I-type arithmetic, decoded from op
    } alu_class_t;

    // Datapath strobes produced by the FSM (alu_control comes from the decoder)
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // Logical immediates are zero-extended; everything else is sign-extended
    function automatic logic is_zext_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode for the multicycle controller.
// Ports:
//   alu_class_i     in  2  kind of ALU operation requested by the FSM state
//   op_i            in  6  opcode, selects and/or/add for I-type arithmetic
//   funct_i         in  6  R-type funct field
//   alu_control_o   out 3  ALU operation code
//   funct_illegal_o out 1  funct not supported (meaningful for R-type only)
// ----------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t  alu_class_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alu_control_o,
    output logic        funct_illegal_o
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alu_control_o   = ALU_ADD;
        funct_illegal_o = 1'b0;
        unique case (alu_class_i)
            ALU_CLS_ADD: alu_control_o = ALU_ADD;
            ALU_CLS_SUB: alu_control_o = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    default:   funct_illegal_o = 1'b1;
                endcase
            end
            ALU_CLS_IMM: begin
                case (op_i)
                    OP_ANDI: alu_control_o = ALU_AND;
                    OP_ORI:  alu_control_o = ALU_OR;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore FSM sequencing a multicycle MIPS datapath (shared memory port, IR,
// register file, ALU, immediate extender). Waits on a memory ready handshake
// and flags unsupported opcodes / R-type functs.
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   op, funct             IR[31:26], IR[5:0]
//   mem_ready             memory access completes this cycle
//   iord, mem_write       memory address select, write strobe
//   ir_write, pc_write    IR load, unconditional PC load
//   branch, pc_src        conditional PC load, PC source select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_control           ALU operation
//   ext_zero              1 = zero-extend immediate, 0 = sign-extend
//   reg_dst, mem_to_reg   register write address / data selects
//   reg_write             register file write enable
//   illegal_op            pulse on unsupported op or funct
//   instr_done            pulse in final state of each legal instruction
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       ext_zero,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t     state_q, state_d;
    alu_class_t alu_class;
    logic [2:0] alu_ctl;
    logic       funct_illegal;
    ctrl_t      ctrl, ctrl_gated;

    // NOTE: reset is sampled on the clock edge only (synchronous), and state
    // uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Kept separate from the main decode so the decoder's illegal flag does
    // not feed back into the block that produces its input.
    always_comb begin
        alu_class = ALU_CLS_ADD;
        case (state_q)
            S_EXECUTE: alu_class = ALU_CLS_FUNCT;
            S_BRANCH:  alu_class = ALU_CLS_SUB;
            S_IEXEC:   alu_class = ALU_CLS_IMM;
            default:   alu_class = ALU_CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class_i     (alu_class),
        .op_i            (op),
        .funct_i         (funct),
        .alu_control_o   (alu_ctl),
        .funct_illegal_o (funct_illegal)
    );

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut while decoding
                ctrl.alu_src_b = SRCB_IMM_SH2;
                case (op)
                    OP_LW, OP_SW:               state_d = S_MEMADR;
                    OP_RTYPE:                   state_d = S_EXECUTE;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
                    OP_J:                       state_d = S_JUMP;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_d         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                if (funct_illegal) begin
                    ctrl.illegal_op = 1'b1;
                    state_d         = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.branch     = 1'b1;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_zero  = is_zext_imm(op);
                state_d        = S_IWB;
            end
            S_IWB: begin
                // Extension mode held so the immediate stays consistent
                ctrl.ext_zero   = is_zext_imm(op);
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every strobe combinationally so an aborted instruction
    // cannot leak a write in the cycle reset is asserted.
    assign ctrl_gated  = reset_n ? ctrl : '0;
    assign alu_control = reset_n ? alu_ctl : 3'b000;

    assign iord       = ctrl_gated.iord;
    assign mem_write  = ctrl_gated.mem_write;
    assign ir_write   = ctrl_gated.ir_write;
    assign pc_write   = ctrl_gated.pc_write;
    assign branch     = ctrl_gated.branch;
    assign pc_src     = ctrl_gated.pc_src;
    assign alu_src_a  = ctrl_gated.alu_src_a;
    assign alu_src_b  = ctrl_gated.alu_src_b;
    assign ext_zero   = ctrl_gated.ext_zero;
    assign reg_dst    = ctrl_gated.reg_dst;
    assign mem_to_reg = ctrl_gated.mem_to_reg;
    assign reg_write  = ctrl_gated.reg_write;
    assign illegal_op = ctrl_gated.illegal_op;
    assign instr_done = ctrl_gated.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Table-driven check of the multicycle MIPS controller: one record per clock
// cycle with inputs and the full expected output bundle, plus hand-written
// sequences for reset abort and instruction cycle counts.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       ext_zero;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] funct;
        logic       mr;
        outs_t      exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = T_LW;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b1;
    outs_t      dut_o;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .iord        (dut_o.iord),
        .mem_write   (dut_o.mem_write),
        .ir_write    (dut_o.ir_write),
        .pc_write    (dut_o.pc_write),
        .branch      (dut_o.branch),
        .pc_src      (dut_o.pc_src),
        .alu_src_a   (dut_o.alu_src_a),
        .alu_src_b   (dut_o.alu_src_b),
        .alu_control (dut_o.alu_control),
        .ext_zero    (dut_o.ext_zero),
        .reg_dst     (dut_o.reg_dst),
        .mem_to_reg  (dut_o.mem_to_reg),
        .reg_write   (dut_o.reg_write),
        .illegal_op  (dut_o.illegal_op),
        .instr_done  (dut_o.instr_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected output bundles, written directly from the state descriptions
    function automatic outs_t e_base();
        outs_t o = '0;
        o.alu_control = 3'b010;
        return o;
    endfunction
    function automatic outs_t e_fetch(input logic mr);
        outs_t o = e_base();
        o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr;
        return o;
    endfunction
    function automatic outs_t e_decode(input logic ill);
        outs_t o = e_base();
        o.alu_src_b = 2'b11; o.illegal_op = ill;
        return o;
    endfunction
    function automatic outs_t e_memadr();
        outs_t o = e_base();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outs_t e_memrd();
        outs_t o = e_base();
        o.iord = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_memwb();
        outs_t o = e_base();
        o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_memwr(input logic mr);
        outs_t o = e_base();
        o.iord = 1'b1; o.mem_write = 1'b1; o.instr_done = mr;
        return o;
    endfunction
    function automatic outs_t e_exec(input logic [2:0] alu, input logic ill);
        outs_t o = e_base();
        o.alu_src_a = 1'b1; o.alu_control = alu; o.illegal_op = ill;
        return o;
    endfunction
    function automatic outs_t e_aluwb();
        outs_t o = e_base();
        o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_branch();
        outs_t o = e_base();
        o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.branch = 1'b1;
        o.pc_src = 2'b01; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_iexec(input logic [2:0] alu, input logic ez);
        outs_t o = e_base();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = alu; o.ext_zero = ez;
        return o;
    endfunction
    function automatic outs_t e_iwb(input logic ez);
        outs_t o = e_base();
        o.reg_write = 1'b1; o.instr_done = 1'b1; o.ext_zero = ez;
        return o;
    endfunction
    function automatic outs_t e_jump();
        outs_t o = e_base();
        o.pc_src = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic m, input outs_t e, input string n);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.mr = m; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Run one instruction from FETCH with mem_ready=1 and count cycles to instr_done
    task automatic count_cycles(input logic [5:0] o, input int exp_cycles, input string n);
        int  cyc = 0;
        bit  done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            reset_n = 1'b1; op = o; funct = 6'h20; mem_ready = 1'b1;
            #1;
            cyc++;
            if (dut_o.instr_done) done = 1;
        end
        check(n, 32'(cyc), 32'(exp_cycles));
    endtask

    initial begin
        // Reset, with lw on the bus
        add(0, T_LW, 6'h00, 1, '0, "reset_c1");
        add(0, T_LW, 6'h00, 1, '0, "reset_c2");
        // lw, no waits
        add(1, T_LW, 6'h00, 1, e_fetch(1), "lw_fetch");
        add(1, T_LW, 6'h00, 0, e_decode(0), "lw_decode_mr_ignored");
        add(1, T_LW, 6'h00, 0, e_memadr(), "lw_memadr");
        add(1, T_LW, 6'h00, 1, e_memrd(), "lw_memrd");
        add(1, T_LW, 6'h00, 1, e_memwb(), "lw_memwb");
        // lw with a fetch wait and a read wait
        add(1, T_LW, 6'h00, 0, e_fetch(0), "lw2_fetch_wait");
        add(1, T_LW, 6'h00, 1, e_fetch(1), "lw2_fetch");
        add(1, T_LW, 6'h00, 1, e_decode(0), "lw2_decode");
        add(1, T_LW, 6'h00, 1, e_memadr(), "lw2_memadr");
        add(1, T_LW, 6'h00, 0, e_memrd(), "lw2_memrd_wait");
        add(1, T_LW, 6'h00, 1, e_memrd(), "lw2_memrd");
        add(1, T_LW, 6'h00, 1, e_memwb(), "lw2_memwb");
        // sw with three write wait cycles
        add(1, T_SW, 6'h00, 1, e_fetch(1), "sw_fetch");
        add(1, T_SW, 6'h00, 1, e_decode(0), "sw_decode");
        add(1, T_SW, 6'h00, 1, e_memadr(), "sw_memadr");
        add(1, T_SW, 6'h00, 0, e_memwr(0), "sw_memwr_w1");
        add(1, T_SW, 6'h00, 0, e_memwr(0), "sw_memwr_w2");
        add(1, T_SW, 6'h00, 0, e_memwr(0), "sw_memwr_w3");
        add(1, T_SW, 6'h00, 1, e_memwr(1), "sw_memwr_done");
        // R-type, each legal funct
        add(1, T_R, 6'h20, 1, e_fetch(1), "radd_fetch");
        add(1, T_R, 6'h20, 1, e_decode(0), "radd_decode");
        add(1, T_R, 6'h20, 1, e_exec(3'b010, 0), "radd_exec");
        add(1, T_R, 6'h20, 1, e_aluwb(), "radd_aluwb");
        add(1, T_R, 6'h22, 1, e_fetch(1), "rsub_fetch");
        add(1, T_R, 6'h22, 1, e_decode(0), "rsub_decode");
        add(1, T_R, 6'h22, 1, e_exec(3'b110, 0), "rsub_exec");
        add(1, T_R, 6'h22, 1, e_aluwb(), "rsub_aluwb");
        add(1, T_R, 6'h24, 1, e_fetch(1), "rand_fetch");
        add(1, T_R, 6'h24, 1, e_decode(0), "rand_decode");
        add(1, T_R, 6'h24, 1, e_exec(3'b000, 0), "rand_exec");
        add(1, T_R, 6'h24, 1, e_aluwb(), "rand_aluwb");
        add(1, T_R, 6'h25, 1, e_fetch(1), "ror_fetch");
        add(1, T_R, 6'h25, 1, e_decode(0), "ror_decode");
        add(1, T_R, 6'h25, 1, e_exec(3'b001, 0), "ror_exec");
        add(1, T_R, 6'h25, 1, e_aluwb(), "ror_aluwb");
        add(1, T_R, 6'h2A, 1, e_fetch(1), "rslt_fetch");
        add(1, T_R, 6'h2A, 1, e_decode(0), "rslt_decode");
        add(1, T_R, 6'h2A, 1, e_exec(3'b111, 0), "rslt_exec");
        add(1, T_R, 6'h2A, 1, e_aluwb(), "rslt_aluwb");
        // R-type with unsupported funct: illegal in EXECUTE, then FETCH
        add(1, T_R, 6'h3F, 1, e_fetch(1), "rbad_fetch");
        add(1, T_R, 6'h3F, 1, e_decode(0), "rbad_decode");
        add(1, T_R, 6'h3F, 1, e_exec(3'b010, 1), "rbad_exec_illegal");
        add(1, T_R, 6'h3F, 0, e_fetch(0), "rbad_back_to_fetch");
        // Immediates with imm=16'h8000 on the datapath
        add(1, T_ANDI, 6'h00, 1, e_fetch(1), "andi_fetch");
        add(1, T_ANDI, 6'h00, 1, e_decode(0), "andi_decode");
        add(1, T_ANDI, 6'h00, 1, e_iexec(3'b000, 1), "andi_iexec");
        add(1, T_ANDI, 6'h00, 1, e_iwb(1), "andi_iwb");
        add(1, T_ADDI, 6'h00, 1, e_fetch(1), "addi_fetch");
        add(1, T_ADDI, 6'h00, 1, e_decode(0), "addi_decode");
        add(1, T_ADDI, 6'h00, 1, e_iexec(3'b010, 0), "addi_iexec");
        add(1, T_ADDI, 6'h00, 1, e_iwb(0), "addi_iwb");
        add(1, T_ORI, 6'h00, 1, e_fetch(1), "ori_fetch");
        add(1, T_ORI, 6'h00, 1, e_decode(0), "ori_decode");
        add(1, T_ORI, 6'h00, 1, e_iexec(3'b001, 1), "ori_iexec");
        add(1, T_ORI, 6'h00, 1, e_iwb(1), "ori_iwb");
        // beq, j
        add(1, T_BEQ, 6'h00, 1, e_fetch(1), "beq_fetch");
        add(1, T_BEQ, 6'h00, 1, e_decode(0), "beq_decode");
        add(1, T_BEQ, 6'h00, 0, e_branch(), "beq_branch");
        add(1, T_J, 6'h00, 1, e_fetch(1), "j_fetch");
        add(1, T_J, 6'h00, 1, e_decode(0), "j_decode");
        add(1, T_J, 6'h00, 0, e_jump(), "j_jump");
        // Unsupported opcode
        add(1, T_BAD, 6'h00, 1, e_fetch(1), "bad_fetch");
        add(1, T_BAD, 6'h00, 1, e_decode(1), "bad_decode_illegal");
        add(1, T_BAD, 6'h00, 0, e_fetch(0), "bad_back_to_fetch");

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = vecs[i].rst_n;
            op        = vecs[i].op;
            funct     = vecs[i].funct;
            mem_ready = vecs[i].mr;
            #1;
            check(vecs[i].name, 32'(dut_o), 32'(vecs[i].exp));
        end

        // Reset asserted during a sw write wait aborts the write immediately
        @(negedge clk); reset_n = 1'b1; op = T_SW; mem_ready = 1'b1; #1;
        check("abort_fetch", 32'(dut_o), 32'(e_fetch(1)));
        @(negedge clk); #1;
        check("abort_decode", 32'(dut_o), 32'(e_decode(0)));
        @(negedge clk); #1;
        check("abort_memadr", 32'(dut_o), 32'(e_memadr()));
        @(negedge clk); mem_ready = 1'b0; #1;
        check("abort_memwr_wait", 32'(dut_o), 32'(e_memwr(0)));
        @(negedge clk); reset_n = 1'b0; #1;
        check("abort_mem_write_low", 32'(dut_o.mem_write), 32'd0);
        check("abort_all_zero", 32'(dut_o), 32'd0);
        @(negedge clk); reset_n = 1'b1; mem_ready = 1'b0; #1;
        check("abort_then_fetch", 32'(dut_o), 32'(e_fetch(0)));

        // Cycle counts from FETCH to instr_done with mem_ready held high
        count_cycles(T_J,    3, "cycles_j");
        count_cycles(T_BEQ,  3, "cycles_beq");
        count_cycles(T_LW,   5, "cycles_lw");
        count_cycles(T_SW,   4, "cycles_sw");
        count_cycles(T_R,    4, "cycles_r");
        count_cycles(T_ADDI, 4, "cycles_addi");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
